// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle sequencing controller for the processor datapath.
// It latches the fetched instruction, then steps FETCH/DECODE/EXEC/MEM/WB.
// Memory, PC, register-file, ALU-source and extender selects are decoded from
// the state and the latched instruction.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   FETCH  | iREN high until ihit; on ihit latch ir and write PC+4
//   DECODE | J/JAL resolve here; HALT_OP parks the core; unknown op = NOP
//   EXEC   | branches and JR resolve here; loads/stores go on to MEM
//   MEM    | dREN (LW) or dWEN (SW) held until dhit
//   WB     | single-cycle register-file write
//   HALT   | halt high, everything else low, left only through nRST
module multicycle_ctrl #(
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] instr,
    input  logic        aluZero,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic        pcWEN,
    output logic [1:0]  pcSrc,
    output logic        extZero,
    output logic        extLui,
    output logic        extShift,
    output logic        aluSrcImm,
    output logic        regWEN,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic [31:0] ir,
    output logic        halt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [5:0] op, fn;
    logic       is_r, is_lw, is_sw, is_alui, is_shift, is_jr, is_known;
    logic       ext_zero, ext_lui, imm_b;

    logic       iren_c, dren_c, dwen_c, pcwen_c, regwen_c, halt_c;
    logic       extzero_c, extlui_c, extshift_c, alusrc_c;
    logic [1:0] pcsrc_c, regdst_c, memtoreg_c;

    // Instruction-class decode from the latched instruction only.
    always_comb begin
        op       = ir_q[31:26];
        fn       = ir_q[5:0];
        is_r     = (op == OP_RTYPE);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_alui  = (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU) ||
                   (op == OP_ANDI)  || (op == OP_ORI)  || (op == OP_XORI)  ||
                   (op == OP_LUI);
        is_shift = is_r && ((fn == FN_SLL) || (fn == FN_SRL));
        is_jr    = is_r && (fn == FN_JR);
        is_known = is_r || is_alui || is_lw || is_sw ||
                   (op == OP_J) || (op == OP_JAL) ||
                   (op == OP_BEQ) || (op == OP_BNE);
        ext_zero = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        ext_lui  = (op == OP_LUI);
        imm_b    = is_alui || is_lw || is_sw || is_shift;
    end

    // State and instruction registers; reset abandons any instruction in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        iren_c     = 1'b0;
        dren_c     = 1'b0;
        dwen_c     = 1'b0;
        pcwen_c    = 1'b0;
        pcsrc_c    = 2'd0;
        regwen_c   = 1'b0;
        regdst_c   = 2'd0;
        memtoreg_c = 2'd0;
        halt_c     = 1'b0;
        extzero_c  = 1'b0;
        extlui_c   = 1'b0;
        extshift_c = 1'b0;
        alusrc_c   = 1'b0;

        // Extender and ALU-B selects hold for the whole EXEC..WB window.
        if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
            extzero_c  = ext_zero;
            extlui_c   = ext_lui;
            extshift_c = is_shift;
            alusrc_c   = imm_b;
        end

        case (state_q)
            S_FETCH: begin
                iren_c = 1'b1;
                if (ihit) begin
                    ir_d    = instr;
                    pcwen_c = 1'b1;
                    pcsrc_c = 2'd0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == HALT_OP) begin
                    state_d = S_HALT;
                end else if ((op == OP_J) || (op == OP_JAL)) begin
                    pcwen_c = 1'b1;
                    pcsrc_c = 2'd2;
                    if (op == OP_JAL) begin
                        regwen_c   = 1'b1;
                        regdst_c   = 2'd2;
                        memtoreg_c = 2'd2;
                    end
                    state_d = S_FETCH;
                end else if (!is_known) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_BEQ) begin
                    pcwen_c = aluZero;
                    pcsrc_c = 2'd1;
                    state_d = S_FETCH;
                end else if (op == OP_BNE) begin
                    pcwen_c = !aluZero;
                    pcsrc_c = 2'd1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pcwen_c = 1'b1;
                    pcsrc_c = 2'd3;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dren_c = is_lw;
                dwen_c = is_sw;
                if (dhit) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                regwen_c   = 1'b1;
                regdst_c   = is_r ? 2'd1 : 2'd0;
                memtoreg_c = is_lw ? 2'd1 : 2'd0;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halt_c     = 1'b1;
                extzero_c  = 1'b0;
                extlui_c   = 1'b0;
                extshift_c = 1'b0;
                alusrc_c   = 1'b0;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Every output is held low while reset is asserted, iREN included.
    always_comb begin
        iREN      = nRST & iren_c;
        dREN      = nRST & dren_c;
        dWEN      = nRST & dwen_c;
        pcWEN     = nRST & pcwen_c;
        pcSrc     = {2{nRST}} & pcsrc_c;
        extZero   = nRST & extzero_c;
        extLui    = nRST & extlui_c;
        extShift  = nRST & extshift_c;
        aluSrcImm = nRST & alusrc_c;
        regWEN    = nRST & regwen_c;
        regDst    = {2{nRST}} & regdst_c;
        memToReg  = {2{nRST}} & memtoreg_c;
        halt      = nRST & halt_c;
        ir        = {32{nRST}} & ir_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: a behavioural model expands each instruction
// into its expected per-cycle output trace, which is then played against the DUT.
module tb_multicycle_ctrl;

    localparam logic [5:0] HALT_OP = 6'h3F;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic        dhit = 1'b0;
    logic        aluZero = 1'b0;
    logic [31:0] instr = '0;
    logic        iREN, dREN, dWEN, pcWEN, extZero, extLui, extShift;
    logic        aluSrcImm, regWEN, halt;
    logic [1:0]  pcSrc, regDst, memToReg;
    logic [31:0] ir;

    multicycle_ctrl #(.HALT_OP(HALT_OP)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .instr(instr),
        .aluZero(aluZero), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .pcWEN(pcWEN), .pcSrc(pcSrc), .extZero(extZero), .extLui(extLui),
        .extShift(extShift), .aluSrcImm(aluSrcImm), .regWEN(regWEN),
        .regDst(regDst), .memToReg(memToReg), .ir(ir), .halt(halt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       iren, dren, dwen, pcwen;
        logic [1:0] pcsrc;
        logic       ez, el, es, asi, regwen;
        logic [1:0] regdst, m2r;
        logic       halt;
    } outs_t;

    typedef struct {
        logic        ih, dh, az;
        logic [31:0] ins;
        outs_t       o;
        logic [31:0] eir;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] model_ir = '0;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc_n = 0;
    outs_t       obs;

    assign obs = {iREN, dREN, dWEN, pcWEN, pcSrc, extZero, extLui, extShift,
                  aluSrcImm, regWEN, regDst, memToReg, halt};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic known_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A,
                          6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    endfunction

    task automatic chk_o(input string tag, input outs_t e);
        compared++;
        assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic chk_ir(input string tag, input logic [31:0] e);
        compared++;
        assert (ir === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, ir, e);
        end
    endtask

    task automatic push(input logic ih, input logic dh, input logic az,
                        input logic [31:0] ins, input outs_t o);
        cyc_t c;
        c.ih = ih; c.dh = dh; c.az = az; c.ins = ins; c.o = o; c.eir = model_ir;
        q.push_back(c);
    endtask

    // Expand one instruction into the cycles the controller must produce.
    task automatic build(input logic [31:0] ins, input int iw, input int dw,
                         input logic az_v);
        logic [5:0] op, fn;
        logic       is_r, is_lw, is_sw, ext_z, ext_l, ext_s, imm_b;
        outs_t      o;
        op    = ins[31:26];
        fn    = ins[5:0];
        is_r  = (op == 6'h00);
        is_lw = (op == 6'h23);
        is_sw = (op == 6'h2B);
        ext_z = op inside {6'h0C, 6'h0D, 6'h0E};
        ext_l = (op == 6'h0F);
        ext_s = is_r && ((fn == 6'h00) || (fn == 6'h02));
        imm_b = (op inside {6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F})
                || is_lw || is_sw || ext_s;
        for (int k = 0; k < iw; k++) begin
            o = '0; o.iren = 1'b1;
            push(1'b0, rb(), rb(), $urandom, o);
        end
        o = '0; o.iren = 1'b1; o.pcwen = 1'b1;
        push(1'b1, rb(), rb(), ins, o);
        model_ir = ins;
        o = '0;
        if (op == HALT_OP) begin
            push(rb(), rb(), rb(), $urandom, o);
            o.halt = 1'b1;
            repeat (10) push(rb(), rb(), rb(), $urandom, o);
            return;
        end
        if ((op == 6'h02) || (op == 6'h03)) begin
            o.pcwen = 1'b1; o.pcsrc = 2'd2;
            if (op == 6'h03) begin
                o.regwen = 1'b1; o.regdst = 2'd2; o.m2r = 2'd2;
            end
            push(rb(), rb(), rb(), $urandom, o);
            return;
        end
        push(rb(), rb(), rb(), $urandom, o);
        if (!known_op(op)) return;
        o.ez = ext_z; o.el = ext_l; o.es = ext_s; o.asi = imm_b;
        if ((op == 6'h04) || (op == 6'h05)) begin
            o.pcwen = (op == 6'h04) ? az_v : !az_v;
            o.pcsrc = 2'd1;
            push(rb(), rb(), az_v, $urandom, o);
            return;
        end
        if (is_r && (fn == 6'h08)) begin
            o.pcwen = 1'b1; o.pcsrc = 2'd3;
            push(rb(), rb(), rb(), $urandom, o);
            return;
        end
        push(rb(), rb(), rb(), $urandom, o);
        if (is_lw || is_sw) begin
            o.dren = is_lw; o.dwen = is_sw;
            for (int k = 0; k < dw; k++) push(rb(), 1'b0, rb(), $urandom, o);
            push(rb(), 1'b1, rb(), $urandom, o);
            if (is_sw) return;
            o.dren = 1'b0;
        end
        o.regwen = 1'b1;
        o.regdst = is_r ? 2'd1 : 2'd0;
        o.m2r    = is_lw ? 2'd1 : 2'd0;
        push(rb(), rb(), rb(), $urandom, o);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  op, fn;
        r = $urandom;
        case ($urandom_range(0, 15))
            0, 1:    op = 6'h00;
            2:       op = 6'h02;
            3:       op = 6'h03;
            4:       op = 6'h04;
            5:       op = 6'h05;
            6:       op = 6'h09;
            7:       op = 6'h0A;
            8:       op = 6'h0B;
            9:       op = 6'h0C;
            10:      op = 6'h0D;
            11:      op = 6'h0E;
            12:      op = 6'h0F;
            13:      op = 6'h23;
            14:      op = 6'h2B;
            default: op = rb() ? 6'h08 : 6'h20;
        endcase
        case ($urandom_range(0, 5))
            0:       fn = 6'h00;
            1:       fn = 6'h02;
            2:       fn = 6'h08;
            3:       fn = 6'h21;
            4:       fn = 6'h2A;
            default: fn = r[5:0];
        endcase
        if (op == 6'h00) return {op, r[25:6], fn};
        return {op, r[25:0]};
    endfunction

    task automatic run();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge CLK);
            ihit = c.ih; dhit = c.dh; aluZero = c.az; instr = c.ins;
            #1;
            chk_o($sformatf("cyc%0d outs", cyc_n), c.o);
            chk_ir($sformatf("cyc%0d ir", cyc_n), c.eir);
            cyc_n++;
        end
    endtask

    task automatic hold_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            ihit = rb(); dhit = rb(); aluZero = rb(); instr = $urandom;
            #1;
            chk_o("reset outs", '0);
            chk_ir("reset ir", 32'h0);
        end
    endtask

    task automatic release_reset();
        outs_t o;
        @(negedge CLK);
        ihit = 1'b0; dhit = 1'b0;
        nRST = 1'b1;
        #1;
        o = '0; o.iren = 1'b1;
        chk_o("release iREN", o);
        chk_ir("release ir", 32'h0);
    endtask

    initial begin
        hold_reset(3);
        release_reset();

        build(32'h2401FFFF, 0, 0, 1'b0);
        build(32'h34218000, 1, 0, 1'b0);
        build(32'h3C011234, 0, 0, 1'b0);
        build(32'h00011100, 2, 0, 1'b0);
        build(32'h8C220004, 0, 3, 1'b0);
        build(32'h10220003, 0, 0, 1'b1);
        build(32'h10220003, 0, 0, 1'b0);
        build(32'h0C000010, 0, 0, 1'b0);
        run();

        for (int n = 0; n < 40; n++) begin
            build(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rb());
            run();
        end

        // Reset while SW is stalled in MEM with dWEN high.
        build(32'hAC220008, 0, 5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc_t c;
            c = q.pop_front();
            @(negedge CLK);
            ihit = c.ih; dhit = c.dh; aluZero = c.az; instr = c.ins;
            #1;
            chk_o($sformatf("sw cyc%0d outs", k), c.o);
        end
        #2;
        nRST = 1'b0;
        #1;
        chk_o("async reset outs", '0);
        chk_ir("async reset ir", 32'h0);
        q.delete();
        model_ir = '0;
        hold_reset(2);
        release_reset();

        for (int n = 0; n < 8; n++) build(rand_instr(), $urandom_range(0, 2),
                                          $urandom_range(0, 2), rb());
        build({HALT_OP, 26'h0}, 1, 0, 1'b0);
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
